// File: rtl/ysyx_22051468_lsu_pkg.sv
// Shared types and constants for the load/store unit: size/sign encodings,
// FSM states and the registered bus request payload.
package ysyx_22051468_lsu_pkg;

    localparam int unsigned WIDTH  = 64;
    localparam int unsigned STRB_W = WIDTH / 8;
    localparam int unsigned OFF_W  = 3;
    localparam int unsigned RD_W   = 5;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;
    localparam logic [2:0] F3_DX = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef struct packed {
        logic              we;
        logic [WIDTH-1:0]  addr;
        logic [WIDTH-1:0]  wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

    // Stores with any unsigned-class code and loads with 111 fall back to a doubleword.
    function automatic size_e decode_size(input logic is_load, input logic [2:0] f3);
        if (!is_load && f3[2]) return SZ_D;
        if (f3 == F3_DX)       return SZ_D;
        return size_e'(f3[1:0]);
    endfunction

endpackage

// File: rtl/ysyx_22051468_lsu_align.sv
// Combinational lane steering: store strobes/data, load extraction/extension, misalign flag.
// LSU_MISALIGN_TRAP_EN: flag size-misaligned offsets; otherwise low bits are forced aligned.
module ysyx_22051468_lsu_align
    import ysyx_22051468_lsu_pkg::*;
(
    input  logic              is_load_i,
    input  logic [2:0]        funct3_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [WIDTH-1:0]  rdata_i,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [WIDTH-1:0]  wdata_o,
    output logic [WIDTH-1:0]  rdata_o,
    output logic              misalign_o
);

    size_e             size;
    logic              uns;
    logic [OFF_W-1:0]  mask;
    logic [OFF_W-1:0]  off_eff;
    logic [STRB_W-1:0] base;
    logic [WIDTH-1:0]  shifted;

    always_comb begin
        size    = decode_size(is_load_i, funct3_i);
        uns     = is_load_i && funct3_i[2] && (funct3_i != F3_DX);
        mask    = '0;
        base    = '1;
        rdata_o = '0;
        case (size)
            SZ_B:    begin mask = 3'b111; base = 8'h01; end
            SZ_H:    begin mask = 3'b110; base = 8'h03; end
            SZ_W:    begin mask = 3'b100; base = 8'h0F; end
            default: begin mask = 3'b000; base = 8'hFF; end
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_o = |(off_i & ~mask);
`else
        misalign_o = 1'b0;
`endif
        off_eff = off_i & mask;
        wstrb_o = base << off_eff;
        wdata_o = wdata_i << {off_eff, 3'b000};
        shifted = rdata_i >> {off_eff, 3'b000};
        case (size)
            SZ_B:    rdata_o = uns ? WIDTH'(shifted[7:0])
                                   : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
            SZ_H:    rdata_o = uns ? WIDTH'(shifted[15:0])
                                   : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
            SZ_W:    rdata_o = uns ? WIDTH'(shifted[31:0])
                                   : {{(WIDTH-32){shifted[31]}}, shifted[31:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_22051468_lsu.sv
// Load/store unit: IDLE/REQ/WAIT bus FSM, captured request fields and registered write-back.
module ysyx_22051468_lsu
    import ysyx_22051468_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              is_load_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [WIDTH-1:0]  addr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [RD_W-1:0]   rd_addr_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_we_o,
    output logic [WIDTH-1:0]  mem_req_addr_o,
    output logic [WIDTH-1:0]  mem_req_wdata_o,
    output logic [STRB_W-1:0] mem_req_wstrb_o,
    input  logic              mem_rsp_valid_i,
    output logic              mem_rsp_ready_o,
    input  logic [WIDTH-1:0]  mem_rsp_rdata_i,
    output logic              wb_en_o,
    output logic [RD_W-1:0]   wb_addr_o,
    output logic [WIDTH-1:0]  wb_data_o,
    output logic              done_o,
    output logic              misalign_o,
    output logic              hold_pipeline_o
);

    state_e            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              ld_q, ld_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              done_q, done_d;
    logic              wb_en_q, wb_en_d;
    logic [RD_W-1:0]   wb_addr_q, wb_addr_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic              mis_q, mis_d;

    logic              idle;
    logic              al_is_load;
    logic [2:0]        al_f3;
    logic [OFF_W-1:0]  al_off;
    logic [STRB_W-1:0] al_wstrb;
    logic [WIDTH-1:0]  al_wdata;
    logic [WIDTH-1:0]  al_rdata;
    logic              al_misalign;

    // In IDLE the aligner looks at the incoming op; afterwards at the captured one.
    assign idle       = (state_q == ST_IDLE);
    assign al_is_load = idle ? is_load_i      : ld_q;
    assign al_f3      = idle ? funct3_i       : f3_q;
    assign al_off     = idle ? addr_i[2:0]    : off_q;

    ysyx_22051468_lsu_align u_align (
        .is_load_i  (al_is_load),
        .funct3_i   (al_f3),
        .off_i      (al_off),
        .wdata_i    (wdata_i),
        .rdata_i    (mem_rsp_rdata_i),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ld_d      = ld_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rd_d      = rd_q;
        done_d    = 1'b0;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        mis_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i && (is_load_i || is_store_i)) begin
                    if (al_misalign) begin
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end else begin
                        state_d     = ST_REQ;
                        ld_d        = is_load_i;
                        f3_d        = funct3_i;
                        off_d       = addr_i[2:0];
                        rd_d        = rd_addr_i;
                        req_d.we    = !is_load_i;
                        req_d.addr  = {addr_i[WIDTH-1:OFF_W], OFF_W'(0)};
                        req_d.wdata = is_load_i ? '0 : al_wdata;
                        req_d.wstrb = is_load_i ? '0 : al_wstrb;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (ld_q) begin
                        wb_en_d   = (rd_q != '0);
                        wb_addr_d = rd_q;
                        wb_data_d = al_rdata;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            ld_q      <= 1'b0;
            f3_q      <= '0;
            off_q     <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ld_q      <= ld_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            mis_q     <= mis_d;
        end
    end

    assign in_ready_o      = idle;
    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_rsp_ready_o = (state_q == ST_WAIT);
    assign mem_req_we_o    = req_q.we;
    assign mem_req_addr_o  = req_q.addr;
    assign mem_req_wdata_o = req_q.wdata;
    assign mem_req_wstrb_o = req_q.wstrb;
    assign wb_en_o         = wb_en_q;
    assign wb_addr_o       = wb_addr_q;
    assign wb_data_o       = wb_data_q;
    assign done_o          = done_q;
    assign misalign_o      = mis_q;
    assign hold_pipeline_o = (in_valid_i && (is_load_i || is_store_i)) || !idle;

endmodule
